imem_loadable: RTL and testbench
================================

# imem_loadable

Parametrised instruction memory for the 16-bit lab CPU. It replaces the fixed reset-time program image with a byte-stream load port, so programs can be downloaded (e.g. from the UART front end) without resynthesis. The CPU fetch port keeps the existing semantics: byte address in, word out, combinational read. A sequential clear/load controller owns all memory writes and stalls fetch via BUSY.

## Interface
- DATA_W, 16: instruction width in bits; must be a multiple of 8.
- ADDR_W, 8: fetch byte-address width.
- DEPTH, 128: number of words; DEPTH ≤ 2^(ADDR_W − log2(DATA_W/8)).

- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  reset, synchronous, active-high.
- ADDR  in  ADDR_W  CPU fetch byte address; word index = ADDR >> log2(DATA_W/8).
- Q  out  DATA_W  fetched instruction, combinational from ADDR.
- BUSY  out  1  high in CLEAR and LOAD; the CPU must hold its PC while high.
- LD_START  in  1  one-cycle request to begin a load; sampled only in IDLE.
- LD_VALID  in  1  LD_BYTE is valid.
- LD_BYTE  in  8  load data, most-significant byte of each word first.
- LD_LAST  in  1  qualifies the final byte of the program; sampled with LD_VALID.
- LD_READY  out  1  high only in LOAD; a byte is accepted when LD_VALID & LD_READY.
- LD_ERR  out  1  sticky error from the last load; cleared by LD_START or RESET.
- WORDS  out  clog2(DEPTH+1)  count of words written by the last load.

## Operation
- States: CLEAR, IDLE, LOAD.
- RESET high: state = CLEAR, clear index = 0, WORDS = 0, LD_ERR = 0, and byte phase / load index reset to 0. Outputs under reset: BUSY = 1, LD_READY = 0, Q = 0.
- CLEAR: each cycle writes 0 to mem[clear index] and increments the index. After mem[DEPTH−1] is written, the next state is IDLE. LD_START is ignored.
- IDLE: BUSY = 0. LD_START = 1 moves to LOAD and sets load index = 0, byte phase = 0, WORDS = 0, LD_ERR = 0.
- LOAD: LD_READY = 1. Each accepted byte shifts into the assembly register.
  - On the accepted byte with phase = DATA_W/8 − 1, the assembled word is written to mem[load index] on that same edge. The load index and WORDS then increment and the phase returns to 0.
  - LD_LAST on a word-final byte: write the word, then go to IDLE with LD_ERR = 0.
  - LD_LAST on a mid-word byte: discard the partial word (no write), go to IDLE, set LD_ERR = 1.
  - Overflow: if the word at index DEPTH−1 is written without LD_LAST, go to IDLE with LD_ERR = 1 and stop accepting bytes. Memory keeps the DEPTH words written.
  - LD_START while in LOAD is ignored.
- Unloaded words keep their cleared value (0) until the next RESET; a new load overwrites only indices 0..WORDS−1.
- Fetch:
  - Q = mem[ADDR >> log2(DATA_W/8)] when BUSY = 0 and the word index < DEPTH.
  - Q = 0 (NOP) when BUSY = 1 or the word index ≥ DEPTH.
  - Low ADDR bits below word granularity are ignored.
- RESET mid-load aborts the load and re-enters CLEAR; all loaded contents are lost.

## Timing
- Clear latency: BUSY falls on the DEPTH-th rising edge after RESET deasserts. It stays high for exactly DEPTH cycles after the reset cycle.
- LD_START sampled in IDLE at edge n: LD_READY and BUSY are high from edge n onward. The earliest byte is accepted at edge n+1.
- A word written at edge m is visible on Q after BUSY falls. BUSY falls on the edge that accepts the terminating byte (LD_LAST or overflow), so the program is fetchable in the following cycle.
- One byte is accepted per cycle at most; LD_VALID gaps insert wait cycles without changing the phase.
- No read-during-write hazard: Q is forced to 0 whenever a write can occur.

## Test plan
- Reset clear (DEPTH = 128): pulse RESET for 2 cycles, release → BUSY high for exactly 128 cycles, then low; Q = 0x0000 at ADDR 0x00 and 0xFE.
- Normal load: LD_START, then bytes F0 01 51 7F 2A 7A with LD_LAST on 7A → WORDS = 3, LD_ERR = 0. Fetch gives ADDR 0x00 → 0xF001, 0x02 → 0x517F, 0x03 → 0x517F, 0x04 → 0x2A7A, 0x06 → 0x0000.
- Backpressure gaps: the same bytes with LD_VALID low on alternate cycles → identical memory contents and WORDS = 3.
- Mid-word LD_LAST: bytes 12 34 56 with LD_LAST on 56 → WORDS = 1, LD_ERR = 1, ADDR 0x02 → 0x0000. A later LD_START clears LD_ERR.
- Overflow: with DEPTH = 4, stream 10 bytes without LD_LAST → WORDS = 4, LD_ERR = 1, LD_READY low after the 8th accepted byte; bytes 9–10 are not accepted.
- Reset mid-load: assert RESET after 3 accepted bytes → CLEAR re-runs, WORDS = 0, and all fetches return 0x0000 once BUSY falls.

Source files
------------

// File: rtl/imem_loadable_if.sv
// Fetch and byte-stream load bus of the loadable instruction memory.
// The master is the CPU/loader side; the slave is the memory.
interface imem_loadable_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128
);
    localparam int WORDS_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  ADDR;
    logic [DATA_W-1:0]  Q;
    logic               BUSY;
    logic               LD_START;
    logic               LD_VALID;
    logic [7:0]         LD_BYTE;
    logic               LD_LAST;
    logic               LD_READY;
    logic               LD_ERR;
    logic [WORDS_W-1:0] WORDS;

    modport master (
        output ADDR, LD_START, LD_VALID, LD_BYTE, LD_LAST,
        input  Q, BUSY, LD_READY, LD_ERR, WORDS
    );

    modport slave (
        input  ADDR, LD_START, LD_VALID, LD_BYTE, LD_LAST,
        output Q, BUSY, LD_READY, LD_ERR, WORDS
    );
endinterface

// File: rtl/imem_loadable.sv
// Instruction memory with a clear-on-reset sweep and a byte-stream program loader.
// Fetch is combinational and returns NOP whenever the controller may be writing.
module imem_loadable #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic           CLK,
    input  logic           RESET,
    imem_loadable_if.slave bus
);
    localparam int BYTES   = DATA_W / 8;
    localparam int SHIFT   = $clog2(BYTES);
    localparam int PH_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORDS_W = $clog2(DEPTH + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_LOAD
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_clr_idx;
    logic [IDX_W-1:0]     r_ld_idx;
    logic [PH_W-1:0]      r_phase;
    logic [WORDS_W-1:0]   r_words;
    logic                 r_err;
    logic                 r_busy;
    logic                 r_ready;

    logic [DATA_W-1:0]    r_mem [DEPTH];

    logic                 w_accept;
    logic                 w_word_end;
    logic [DATA_W-1:0]    w_word;
    logic                 w_we;
    logic [IDX_W-1:0]     w_waddr;
    logic [DATA_W-1:0]    w_wdata;
    logic [ADDR_W-1:0]    w_widx;
    logic                 w_in_range;

    assign w_accept   = (r_state == S_LOAD) && bus.LD_VALID;
    assign w_word_end = w_accept && (r_phase == PH_LAST);

    // Earlier bytes of the word sit in the upper lanes; the incoming byte completes the LSB.
    generate
        if (BYTES > 1) begin : g_asm
            logic [DATA_W-9:0] r_asm;

            always_ff @(posedge CLK) begin
                if (w_accept) begin
                    r_asm <= w_word[DATA_W-9:0];
                end
            end

            assign w_word = {r_asm, bus.LD_BYTE};
        end else begin : g_no_asm
            assign w_word = bus.LD_BYTE;
        end
    endgenerate

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ld_idx;
        w_wdata = w_word;
        if (!RESET) begin
            if (r_state == S_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_clr_idx;
                w_wdata = '0;
            end else if (w_word_end) begin
                w_we = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_ld_idx  <= '0;
            r_phase   <= '0;
            r_words   <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + IDX_W'(1);
                    if (r_clr_idx == IDX_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_IDLE: begin
                    if (bus.LD_START) begin
                        r_state  <= S_LOAD;
                        r_ld_idx <= '0;
                        r_phase  <= '0;
                        r_words  <= '0;
                        r_err    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_ready  <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (w_accept) begin
                        if (r_phase == PH_LAST) begin
                            r_phase  <= '0;
                            r_ld_idx <= r_ld_idx + IDX_W'(1);
                            r_words  <= r_words + WORDS_W'(1);
                            if (bus.LD_LAST) begin
                                r_state <= S_IDLE;
                                r_err   <= 1'b0;
                                r_busy  <= 1'b0;
                                r_ready <= 1'b0;
                            end else if (r_ld_idx == IDX_LAST) begin
                                // Memory is full: keep what was written, flag the truncation.
                                r_state <= S_IDLE;
                                r_err   <= 1'b1;
                                r_busy  <= 1'b0;
                                r_ready <= 1'b0;
                            end
                        end else if (bus.LD_LAST) begin
                            // Program ended mid-word: the partial word is dropped.
                            r_state <= S_IDLE;
                            r_phase <= '0;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b0;
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end
                    end
                end

                default: begin
                    r_state   <= S_CLEAR;
                    r_clr_idx <= '0;
                    r_busy    <= 1'b1;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign w_widx     = bus.ADDR >> SHIFT;
    assign w_in_range = {1'b0, w_widx} < (ADDR_W + 1)'(DEPTH);

    assign bus.Q        = (r_busy || RESET || !w_in_range) ? '0 : r_mem[w_widx[IDX_W-1:0]];
    assign bus.BUSY     = r_busy;
    assign bus.LD_READY = r_ready;
    assign bus.LD_ERR   = r_err;
    assign bus.WORDS    = r_words;
endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench: a DEPTH=128 memory for the main scenarios and a DEPTH=4 one for overflow.
module tb_imem_loadable;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    imem_loadable_if #(.DATA_W(16), .ADDR_W(8), .DEPTH(128)) b0 ();
    imem_loadable_if #(.DATA_W(16), .ADDR_W(8), .DEPTH(4))   b1 ();

    imem_loadable #(.DATA_W(16), .ADDR_W(8), .DEPTH(128)) u0 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (b0)
    );

    imem_loadable #(.DATA_W(16), .ADDR_W(8), .DEPTH(4)) u1 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start0();
        b0.LD_START = 1'b1;
        @(posedge clk); #1;
        b0.LD_START = 1'b0;
    endtask

    task automatic send0(input logic [7:0] b, input logic last);
        b0.LD_VALID = 1'b1;
        b0.LD_BYTE  = b;
        b0.LD_LAST  = last;
        @(posedge clk); #1;
        b0.LD_VALID = 1'b0;
        b0.LD_LAST  = 1'b0;
        $display("byte %h last=%0b busy=%0b words=%0d err=%0b", b, last, b0.BUSY, b0.WORDS, b0.LD_ERR);
    endtask

    task automatic test_reset();
        int n;
        logic [7:0] addrs [2];
        addrs[0] = 8'h00;
        addrs[1] = 8'hFE;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (b0.BUSY !== 1'b1 || b0.LD_READY !== 1'b0 || b0.Q !== 16'h0000)
            $display("FAIL reset_outputs: got busy=%b ready=%b q=%h required 1 0 0000", b0.BUSY, b0.LD_READY, b0.Q);
        else n_pass++;
        n_checks++;
        if (b0.WORDS !== 8'd0 || b0.LD_ERR !== 1'b0)
            $display("FAIL reset_regs: got words=%0d err=%b required 0 0", b0.WORDS, b0.LD_ERR);
        else n_pass++;
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (b0.BUSY === 1'b1 && n < 300);
        $display("clear done after %0d cycles", n);
        n_checks++;
        if (n !== 128) $display("FAIL clear_latency: got %0d cycles required 128", n);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            b0.ADDR = addrs[i];
            #1;
            $display("fetch addr=%h q=%h", addrs[i], b0.Q);
            n_checks++;
            if (b0.Q !== 16'h0000) $display("FAIL clear_fetch: addr %h got %h required 0000", addrs[i], b0.Q);
            else n_pass++;
        end
    endtask

    task automatic test_midword_last();
        start0();
        n_checks++;
        if (b0.BUSY !== 1'b1 || b0.LD_READY !== 1'b1)
            $display("FAIL mid_start: got busy=%b ready=%b required 1 1", b0.BUSY, b0.LD_READY);
        else n_pass++;
        send0(8'h12, 1'b0);
        send0(8'h34, 1'b0);
        send0(8'h56, 1'b1);
        n_checks++;
        if (b0.WORDS !== 8'd1 || b0.LD_ERR !== 1'b1 || b0.BUSY !== 1'b0 || b0.LD_READY !== 1'b0)
            $display("FAIL mid_status: got words=%0d err=%b busy=%b ready=%b required 1 1 0 0",
                     b0.WORDS, b0.LD_ERR, b0.BUSY, b0.LD_READY);
        else n_pass++;
        b0.ADDR = 8'h00; #1;
        $display("fetch addr=00 q=%h", b0.Q);
        n_checks++;
        if (b0.Q !== 16'h1234) $display("FAIL mid_fetch0: got %h required 1234", b0.Q);
        else n_pass++;
        b0.ADDR = 8'h02; #1;
        $display("fetch addr=02 q=%h", b0.Q);
        n_checks++;
        if (b0.Q !== 16'h0000) $display("FAIL mid_fetch2: got %h required 0000", b0.Q);
        else n_pass++;
    endtask

    task automatic test_normal_load();
        logic [7:0]  bytes [6];
        logic [7:0]  addrs [6];
        logic [15:0] exps  [6];
        bytes = '{8'hF0, 8'h01, 8'h51, 8'h7F, 8'h2A, 8'h7A};
        addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        exps  = '{16'hF001, 16'hF001, 16'h517F, 16'h517F, 16'h2A7A, 16'h0000};
        start0();
        n_checks++;
        if (b0.LD_ERR !== 1'b0 || b0.WORDS !== 8'd0)
            $display("FAIL start_clears: got err=%b words=%0d required 0 0", b0.LD_ERR, b0.WORDS);
        else n_pass++;
        b0.ADDR = 8'h00; #1;
        n_checks++;
        if (b0.Q !== 16'h0000) $display("FAIL busy_nop: got %h required 0000", b0.Q);
        else n_pass++;
        for (int i = 0; i < 6; i++) send0(bytes[i], i == 5);
        n_checks++;
        if (b0.WORDS !== 8'd3 || b0.LD_ERR !== 1'b0 || b0.BUSY !== 1'b0)
            $display("FAIL load_status: got words=%0d err=%b busy=%b required 3 0 0", b0.WORDS, b0.LD_ERR, b0.BUSY);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            b0.ADDR = addrs[i]; #1;
            $display("fetch addr=%h q=%h", addrs[i], b0.Q);
            n_checks++;
            if (b0.Q !== exps[i]) $display("FAIL load_fetch: addr %h got %h required %h", addrs[i], b0.Q, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  bytes [6];
        logic [15:0] exps  [4];
        bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        exps  = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0000};
        start0();
        for (int i = 0; i < 6; i++) begin
            b0.LD_VALID = 1'b0;
            b0.LD_BYTE  = 8'h99;
            b0.LD_LAST  = 1'b1;
            @(posedge clk); #1;
            b0.LD_LAST  = 1'b0;
            send0(bytes[i], i == 5);
        end
        n_checks++;
        if (b0.WORDS !== 8'd3 || b0.LD_ERR !== 1'b0 || b0.BUSY !== 1'b0)
            $display("FAIL gap_status: got words=%0d err=%b busy=%b required 3 0 0", b0.WORDS, b0.LD_ERR, b0.BUSY);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            b0.ADDR = 8'(2 * i); #1;
            $display("fetch addr=%h q=%h", b0.ADDR, b0.Q);
            n_checks++;
            if (b0.Q !== exps[i]) $display("FAIL gap_fetch: addr %h got %h required %h", b0.ADDR, b0.Q, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exps [5];
        exps = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h0000};
        b1.LD_START = 1'b1;
        @(posedge clk); #1;
        b1.LD_START = 1'b0;
        for (int i = 0; i < 10; i++) begin
            b1.LD_VALID = 1'b1;
            b1.LD_BYTE  = 8'(i + 1);
            b1.LD_LAST  = 1'b0;
            @(posedge clk); #1;
            $display("ovf byte %h ready=%b words=%0d err=%b", b1.LD_BYTE, b1.LD_READY, b1.WORDS, b1.LD_ERR);
            if (i == 6) begin
                n_checks++;
                if (b1.LD_READY !== 1'b1) $display("FAIL ovf_ready7: got %b required 1", b1.LD_READY);
                else n_pass++;
            end
            if (i == 7) begin
                n_checks++;
                if (b1.LD_READY !== 1'b0 || b1.BUSY !== 1'b0)
                    $display("FAIL ovf_ready8: got ready=%b busy=%b required 0 0", b1.LD_READY, b1.BUSY);
                else n_pass++;
            end
        end
        b1.LD_VALID = 1'b0;
        n_checks++;
        if (b1.WORDS !== 3'd4 || b1.LD_ERR !== 1'b1)
            $display("FAIL ovf_status: got words=%0d err=%b required 4 1", b1.WORDS, b1.LD_ERR);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            b1.ADDR = 8'(2 * i); #1;
            $display("ovf fetch addr=%h q=%h", b1.ADDR, b1.Q);
            n_checks++;
            if (b1.Q !== exps[i]) $display("FAIL ovf_fetch: addr %h got %h required %h", b1.ADDR, b1.Q, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midload();
        int n;
        start0();
        send0(8'hAB, 1'b0);
        send0(8'hCD, 1'b0);
        send0(8'hEF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (b0.BUSY !== 1'b1 || b0.WORDS !== 8'd0 || b0.LD_READY !== 1'b0)
            $display("FAIL abort_regs: got busy=%b words=%0d ready=%b required 1 0 0", b0.BUSY, b0.WORDS, b0.LD_READY);
        else n_pass++;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (b0.BUSY === 1'b1 && n < 300);
        n_checks++;
        if (n !== 128) $display("FAIL abort_clear: got %0d cycles required 128", n);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            b0.ADDR = 8'(2 * i);
            b1.ADDR = 8'(2 * i);
            #1;
            $display("post-abort fetch addr=%h q0=%h q1=%h", b0.ADDR, b0.Q, b1.Q);
            n_checks++;
            if (b0.Q !== 16'h0000 || b1.Q !== 16'h0000)
                $display("FAIL abort_fetch: addr %h got %h/%h required 0000", b0.ADDR, b0.Q, b1.Q);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        b0.ADDR = '0; b0.LD_START = 1'b0; b0.LD_VALID = 1'b0; b0.LD_BYTE = '0; b0.LD_LAST = 1'b0;
        b1.ADDR = '0; b1.LD_START = 1'b0; b1.LD_VALID = 1'b0; b1.LD_BYTE = '0; b1.LD_LAST = 1'b0;
        test_reset();
        test_midword_last();
        test_normal_load();
        test_backpressure();
        test_overflow();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
